mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Load/store front-end sitting directly upstream of the data SRAM. Takes one datapath
//  request (byte/half/word, signed/unsigned) and drives the word-only SRAM strobes.
//  Performs read-modify-write for sub-word stores and lane extraction/extension for loads.
//  Stalls the datapath via req_ready while an access is in flight.
// PARAMETERS
//  MEM_AW  8   SRAM word-address width; byte address bits [MEM_AW+1:2] index SRAM.
//  DW      32  data width; fixed at 32, other values unsupported.
// PORTS
//  clk         in   1      clock; all state changes on posedge
//  rst         in   1      synchronous, active-high reset
//  req_valid   in   1      request present
//  req_ready   out  1      high only in IDLE; transfer on req_valid & req_ready
//  req_we      in   1      1 store, 0 load
//  req_size    in   2      00 byte, 01 half, 10 word, 11 treated as word
//  req_signed  in   1      sign-extend loads (ignored for stores/word)
//  req_addr    in   32     byte address, little-endian lanes (byte k = bits 8k+7:8k)
//  req_wdata   in   32     store data, right-justified
//  resp_valid  out  1      one-cycle pulse: access complete
//  resp_rdata  out  32     load result, held until next resp_valid; 0 for stores
//  resp_err    out  1      misalignment flag, qualified by resp_valid
//  sram_cs     out  1      SRAM chip select
//  sram_wr     out  1      SRAM write strobe (SRAM gives write priority over read)
//  sram_rd     out  1      SRAM read strobe
//  sram_addr   out  MEM_AW SRAM word address
//  sram_wdata  out  32     SRAM write word
//  sram_rdata  in   32     SRAM read word; valid the cycle after a read-strobe edge
// BEHAVIOUR
//  - All outputs registered. Reset: state IDLE, req_ready=1, all other outputs 0.
//  - States: IDLE, RD, CAP, WR, RMW_RD, RMW_MRG, RMW_WR, ERR.
//  - IDLE->RD (load), ->WR (word store), ->RMW_RD (byte/half store), ->ERR (misaligned, feature on).
//  - Load: RD cs=rd=1; CAP: sram_rdata lane-extracted/extended into resp_rdata; resp_valid next
//    cycle. Accept-edge to resp_valid: 3 cycles.
//  - Word store: WR cs=wr=1, sram_wdata=req_wdata; resp_valid next cycle. Latency 2.
//  - Sub-word store: RMW_RD read word; RMW_MRG merge req_wdata lane(s) into it; RMW_WR write.
//    Latency 4. Unselected lanes preserved bit-exact.
//  - Strobes high only in RD/WR/RMW_RD/RMW_WR; rd and wr never both 1.
//  - resp_valid high exactly one cycle, coincides with return to IDLE (req_ready=1), so
//    back-to-back accept in the resp_valid cycle is legal.
//  - Address bits above MEM_AW+1 ignored (wrap modulo 2^(MEM_AW+2) bytes).
//  - Request inputs captured at accept; changes afterwards have no effect.
//  - rst mid-operation: return to IDLE, no resp_valid. A write strobe already presented to
//    the SRAM before the reset edge still lands (SRAM has no reset); an RMW in RMW_RD/RMW_MRG
//    is abandoned with memory untouched.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 -> ERR state, no
//    SRAM strobe, resp_valid+resp_err=1 one cycle after ERR, resp_rdata=0.
//  Undefined: low address bits forced to alignment (half: addr[0]=0, word: addr[1:0]=0),
//    access proceeds normally; resp_err tied 0.
// STRUCTURE
//  mem_pkg: size codes, state encoding, MEM_AW default, lane helper constants.
//  Sub-module mem_lane_align (combinational): load extract/sign-extend and store merge,
//  indexed by size and addr[1:0]. FSM and registers stay in mem_access_ctrl.
// TESTING
//  1 word store 0xDEADBEEF @0x10, then word load @0x10 -> resp_rdata=0xDEADBEEF, latencies 2/3.
//  2 byte store 0xA5 @0x11 over 0x11223344 -> word 0x1122A544; signed byte load @0x11 -> 0xFFFFFFA5.
//  3 half store 0x8001 @0x12 over 0x11223344 -> 0x80013344; unsigned half load -> 0x00008001.
//  4 req_valid held high continuously: req_ready low during access, next accept in resp cycle.
//  5 rst asserted in RMW_MRG -> IDLE next cycle, no resp_valid, target word unchanged.
//  6 word load @0x13: with MISALIGN_TRAP_EN resp_err=1, no strobes; without, reads @0x10.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the load/store front-end: size codes, FSM encoding and lane helpers.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE     = 2'b00,
        SZ_HALF     = 2'b01,
        SZ_WORD     = 2'b10,
        SZ_WORD_ALT = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_CAP,
        ST_WR,
        ST_RMW_RD,
        ST_RMW_MRG,
        ST_RMW_WR,
        ST_ERR
    } state_e;

    localparam int          MEM_AW_DEF = 8;
    localparam logic [31:0] BYTE_MASK  = 32'h0000_00FF;
    localparam logic [31:0] HALF_MASK  = 32'h0000_FFFF;

    function automatic logic [31:0] lane_mask(input size_e sz);
        case (sz)
            SZ_BYTE: return BYTE_MASK;
            SZ_HALF: return HALF_MASK;
            default: return '1;
        endcase
    endfunction

    // Misaligned low bits are dropped so the access lands on its natural boundary.
    function automatic logic [1:0] align_off(input size_e sz, input logic [1:0] off);
        case (sz)
            SZ_BYTE: return off;
            SZ_HALF: return {off[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: load extract/extend and sub-word store merge.
module mem_lane_align
    import mem_pkg::*;
(
    input  size_e       size,
    input  logic [1:0]  off,
    input  logic        sign_ext,
    input  logic [31:0] rword,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [4:0]  sh;
    logic [31:0] mask;
    logic [31:0] shifted;
    logic        msb;

    always_comb begin
        sh        = {off, 3'b000};
        mask      = lane_mask(size);
        shifted   = rword >> sh;
        msb       = (size == SZ_BYTE) ? shifted[7] : shifted[15];
        load_data = shifted & mask;
        if (sign_ext && msb && (size != SZ_WORD))
            load_data = load_data | ~mask;
        merge_data = (rword & ~(mask << sh)) | ((wdata & mask) << sh);
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store front-end for a word-only SRAM; read-modify-write for sub-word stores.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses trap with resp_err instead of aligning.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int MEM_AW = MEM_AW_DEF,
    parameter int DW     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [DW-1:0]     req_wdata,
    output logic              resp_valid,
    output logic [DW-1:0]     resp_rdata,
    output logic              resp_err,
    output logic              sram_cs,
    output logic              sram_wr,
    output logic              sram_rd,
    output logic [MEM_AW-1:0] sram_addr,
    output logic [DW-1:0]     sram_wdata,
    input  logic [DW-1:0]     sram_rdata
);

    state_e            state, state_nxt;
    size_e             size_in, size_q;
    logic [1:0]        off_q;
    logic              sgn_q;
    logic [DW-1:0]     wdata_q;
    logic              accept, trap;
    logic [31:0]       load_data, merge_data;
    logic              unused_addr_hi;

    logic              ready_n, resp_valid_n, resp_err_n, cs_n, wr_n, rd_n;
    logic [DW-1:0]     resp_rdata_n, wdata_n;
    logic [MEM_AW-1:0] addr_n;

    assign unused_addr_hi = ^req_addr[31:MEM_AW+2];
    assign accept         = req_valid & req_ready;
    assign size_in        = (req_size == SZ_WORD_ALT) ? SZ_WORD : size_e'(req_size);

`ifdef MISALIGN_TRAP_EN
    assign trap = ((size_in == SZ_HALF) && req_addr[0]) ||
                  ((size_in == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    assign trap = 1'b0;
`endif

    mem_lane_align u_align (
        .size       (size_q),
        .off        (off_q),
        .sign_ext   (sgn_q),
        .rword      (sram_rdata),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (trap)                  state_nxt = ST_ERR;
                    else if (!req_we)          state_nxt = ST_RD;
                    else if (size_in == SZ_WORD) state_nxt = ST_WR;
                    else                       state_nxt = ST_RMW_RD;
                end
            end
            ST_RD:      state_nxt = ST_CAP;
            ST_RMW_RD:  state_nxt = ST_RMW_MRG;
            ST_RMW_MRG: state_nxt = ST_RMW_WR;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are computed from the next state so every port comes straight off a flop.
    always_comb begin
        ready_n      = (state_nxt == ST_IDLE);
        resp_valid_n = (state != ST_IDLE) && (state_nxt == ST_IDLE);
        rd_n         = (state_nxt == ST_RD) || (state_nxt == ST_RMW_RD);
        wr_n         = (state_nxt == ST_WR) || (state_nxt == ST_RMW_WR);
        cs_n         = rd_n | wr_n;
        resp_rdata_n = resp_rdata;
        if (state == ST_CAP)   resp_rdata_n = load_data;
        else if (resp_valid_n) resp_rdata_n = '0;
`ifdef MISALIGN_TRAP_EN
        resp_err_n   = (state == ST_ERR);
`else
        resp_err_n   = 1'b0;
`endif
        addr_n       = accept ? req_addr[MEM_AW+1:2] : sram_addr;
        wdata_n      = sram_wdata;
        if (accept)                    wdata_n = req_wdata;
        else if (state == ST_RMW_MRG)  wdata_n = merge_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            sram_cs    <= 1'b0;
            sram_wr    <= 1'b0;
            sram_rd    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            size_q     <= SZ_BYTE;
            off_q      <= 2'b00;
            sgn_q      <= 1'b0;
            wdata_q    <= '0;
        end else begin
            req_ready  <= ready_n;
            resp_valid <= resp_valid_n;
            resp_rdata <= resp_rdata_n;
            resp_err   <= resp_err_n;
            sram_cs    <= cs_n;
            sram_wr    <= wr_n;
            sram_rd    <= rd_n;
            sram_addr  <= addr_n;
            sram_wdata <= wdata_n;
            if (accept) begin
                size_q  <= size_in;
                off_q   <= align_off(size_in, req_addr[1:0]);
                sgn_q   <= req_signed;
                wdata_q <= req_wdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl against a byte-lane memory model kept in the bench.
module tb_mem_access_ctrl;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_we, req_signed;
    logic [1:0]    req_size;
    logic [31:0]   req_addr, req_wdata;
    logic          resp_valid, resp_err;
    logic [31:0]   resp_rdata;
    logic          sram_cs, sram_wr, sram_rd;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_wdata, sram_rdata;

    logic [31:0]   mem     [0:255];
    logic [31:0]   ref_mem [0:255];
    logic          load_mem;
    int            n_tests = 0;
    int            n_fail  = 0;
    int            strb_cnt = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.MEM_AW(AW), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .sram_cs(sram_cs), .sram_wr(sram_wr), .sram_rd(sram_rd),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    // SRAM: write wins over read, read data registered, no reset.
    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= ref_mem[i];
        end else if (sram_cs) begin
            if (sram_wr)      mem[sram_addr] <= sram_wdata;
            else if (sram_rd) sram_rdata     <= mem[sram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (sram_cs || sram_rd || sram_wr)) begin
            strb_cnt++;
            chk("strobe_excl", {30'd0, sram_cs, sram_rd & sram_wr}, 32'd2);
        end
    end

    // Spec-level model: memory as bytes-in-words, result and timing from the access kind.
    function automatic void ref_access(input bit we, input logic [1:0] sz, input bit sgn,
                                       input logic [31:0] addr, input logic [31:0] wd,
                                       output logic [31:0] e_rd, output bit e_err,
                                       output int e_lat, output int e_strb);
        int k, nb, off, idx;
        logic [63:0] mask, word, v;
        k   = (sz == 2'd3) ? 2 : int'(sz);
        nb  = 1 << k;
        off = int'(addr[1:0]);
        idx = int'(addr[9:2]);
        e_rd  = '0;
        e_err = 1'b0;
`ifdef MISALIGN_TRAP_EN
        if (off % nb != 0) begin
            e_err = 1'b1; e_lat = 2; e_strb = 0;
            return;
        end
`endif
        off  = off - off % nb;
        mask = (64'd1 << (8 * nb)) - 64'd1;
        word = {32'd0, ref_mem[idx]};
        if (we) begin
            word = (word & ~(mask << (8 * off))) | (({32'd0, wd} & mask) << (8 * off));
            ref_mem[idx] = word[31:0];
            e_lat  = (k == 2) ? 2 : 4;
            e_strb = (k == 2) ? 1 : 2;
        end else begin
            v = (word >> (8 * off)) & mask;
            if (sgn && k < 2 && v[8 * nb - 1]) v = v | ~mask;
            e_rd   = v[31:0];
            e_lat  = 3;
            e_strb = 1;
        end
    endfunction

    // Called at posedge+1 with the DUT idle; returns at posedge+1 of the response cycle.
    task automatic do_req(input bit we, input logic [1:0] sz, input bit sgn,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input bit hold, output logic [31:0] rd_o);
        logic [31:0] e_rd;
        bit          e_err;
        int          e_lat, e_strb, lat, base, guard;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        chk("ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sgn;
        req_addr = addr; req_wdata = wd;
        ref_access(we, sz, sgn, addr, wd, e_rd, e_err, e_lat, e_strb);
        @(posedge clk); #1;
        base = strb_cnt;
        if (!hold) begin
            req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
            req_signed = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        end
        lat = 1;
        while (!resp_valid && lat < 20) begin
            chk("ready_busy", 32'(req_ready), 32'd0);
            @(posedge clk); #1; lat++;
        end
        chk("latency", 32'(lat), 32'(e_lat));
        chk("resp_rdata", resp_rdata, e_rd);
        chk("resp_err", 32'(resp_err), 32'(e_err));
        chk("ready_resp", 32'(req_ready), 32'd1);
        chk("strobe_cycles", 32'(strb_cnt - base), 32'(e_strb));
        rd_o = resp_rdata;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] r, a;
        bit          hold;
        int          seen, mism;
        rst = 1'b1; load_mem = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp", {29'd0, resp_valid, resp_err, 1'b0}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_strobes", {29'd0, sram_cs, sram_wr, sram_rd}, 32'd0);
        chk("rst_sram_bus", {24'd0, sram_addr} | sram_wdata, 32'd0);
        load_mem = 1'b0; rst = 1'b0;
        @(posedge clk); #1;

        // Directed: word store/load, byte and half read-modify-write.
        do_req(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0, r);
        do_req(0, 2'd2, 0, 32'h10, 32'h0, 0, r);
        chk("t1_load", r, 32'hDEADBEEF);
        do_req(1, 2'd2, 0, 32'h10, 32'h11223344, 0, r);
        do_req(1, 2'd0, 0, 32'h11, 32'h123456A5, 0, r);
        do_req(0, 2'd2, 0, 32'h10, 32'h0, 0, r);
        chk("t2_word", r, 32'h1122A544);
        do_req(0, 2'd0, 1, 32'h11, 32'h0, 0, r);
        chk("t2_sbyte", r, 32'hFFFFFFA5);
        do_req(1, 2'd2, 0, 32'h10, 32'h11223344, 0, r);
        do_req(1, 2'd1, 0, 32'h12, 32'hFFFF8001, 0, r);
        do_req(0, 2'd2, 0, 32'h10, 32'h0, 0, r);
        chk("t3_word", r, 32'h80013344);
        do_req(0, 2'd1, 0, 32'h12, 32'h0, 0, r);
        chk("t3_uhalf", r, 32'h00008001);
        do_req(0, 2'd2, 0, 32'h13, 32'h0, 0, r);
`ifdef MISALIGN_TRAP_EN
        chk("t6_trap_rdata", r, 32'h0);
`else
        chk("t6_aligned", r, 32'h80013344);
`endif

        // Reset while the sub-word store sits in its merge cycle.
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h21; req_wdata = 32'h5A;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_ready", 32'(req_ready), 32'd1);
        chk("rst_mid_idle", {30'd0, resp_valid, sram_cs}, 32'd0);
        rst = 1'b0;
        seen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (resp_valid) seen++;
        end
        chk("rst_no_resp", 32'(seen), 32'd0);
        chk("rst_mem_kept", mem[8], ref_mem[8]);
        do_req(0, 2'd2, 0, 32'h20, 32'h0, 0, r);

        // Random traffic; held req_valid exercises accept in the response cycle.
        for (int n = 0; n < 250; n++) begin
            a    = ($urandom & 32'hFFFFFC00) | 32'($urandom_range(0, 63));
            hold = 1'($urandom_range(0, 1));
            do_req(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, hold, r);
            if (!hold) begin
                @(posedge clk); #1;
                chk("resp_pulse", 32'(resp_valid), 32'd0);
            end
        end
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        mism = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) mism++;
        chk("mem_image", 32'(mism), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
